sw_target_feeder: RTL and testbench

- Head-of-array driver and tail-of-array result collector for the Smith-Waterman systolic PE chain.
- Accepts target bases from the host over a valid/ready stream and buffers the whole target.
- Replays the buffered target into the first PE as a bubble-free enable burst, with boundary scores at biased ZERO.
- Detects completion from the last PE's vld, then reports the unbiased best score to the host.

---
 rtl/sw_target_feeder.sv | 159 +++++++++++++++
 tb/tb_sw_target_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_target_feeder.sv
`default_nettype none
// ============================================================================
// sw_target_feeder : buffers a host target, replays it into the head of the
//   Smith-Waterman PE chain and reports the unbiased best score from the tail.
//   Optional drain watchdog enabled by defining SW_FEEDER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module sw_target_feeder #(
  parameter int SCORE_WIDTH = 12,
  parameter int ZERO        = 2**(SCORE_WIDTH-1),
  parameter int DEPTH       = 64,
  parameter int CNT_WIDTH   = 7,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             s_base,
  input  logic                   s_last,
  output logic [1:0]             data_out,
  output logic [SCORE_WIDTH-1:0] M_out,
  output logic [SCORE_WIDTH-1:0] I_out,
  output logic [SCORE_WIDTH-1:0] High_out,
  output logic                   en_out,
  input  logic                   res_vld_in,
  input  logic [SCORE_WIDTH-1:0] res_high_in,
  output logic                   score_valid,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   trunc,
  output logic                   busy,
  output logic                   err
);

  localparam int                   AW      = $clog2(DEPTH);
  localparam logic [SCORE_WIDTH-1:0] ZERO_V = SCORE_WIDTH'(ZERO);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAST_C  = CNT_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

  if (DEPTH < 2 || (2**CNT_WIDTH) <= DEPTH || TIMEOUT < 1) begin : g_param_check
    $error("sw_target_feeder: invalid parameter set");
  end

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] rd_ptr;
  logic                 vld_q;
  logic                 accept;
  logic                 done;
  logic [1:0]           mem [DEPTH];

  assign s_ready  = (state == LOAD);
  assign busy     = (state != LOAD);
  assign accept   = s_ready && s_valid;
  assign done     = res_vld_in && !vld_q;
  assign M_out    = ZERO_V;
  assign I_out    = ZERO_V;
  assign High_out = ZERO_V;

  // Beats past DEPTH are accepted but never stored.
  always_ff @(posedge clk) begin
    if (accept && count != DEPTH_C) begin
      mem[count[AW-1:0]] <= s_base;
    end
  end

`ifdef SW_FEEDER_TIMEOUT_EN
  localparam int           TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] drain_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      count       <= '0;
      rd_ptr      <= '0;
      trunc       <= 1'b0;
      en_out      <= 1'b0;
      data_out    <= 2'b00;
      score_valid <= 1'b0;
      score       <= '0;
      vld_q       <= 1'b0;
`ifdef SW_FEEDER_TIMEOUT_EN
      err         <= 1'b0;
      drain_cnt   <= '0;
`endif
    end else begin
      // A stale high vld from the last job is absorbed here before DRAIN.
      vld_q       <= res_vld_in;
      score_valid <= 1'b0;
`ifdef SW_FEEDER_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        LOAD: begin
          if (accept) begin
            if (count != DEPTH_C) count <= count + ONE_C;
            if (count == LAST_C && !s_last) trunc <= 1'b1;
            if (s_last) begin
              rd_ptr <= '0;
              state  <= STREAM;
            end
          end
        end
        STREAM: begin
          data_out <= mem[rd_ptr[AW-1:0]];
          en_out   <= 1'b1;
          rd_ptr   <= rd_ptr + ONE_C;
          if (rd_ptr == count - ONE_C) begin
            state <= DRAIN;
`ifdef SW_FEEDER_TIMEOUT_EN
            drain_cnt <= '0;
`endif
          end
        end
        DRAIN: begin
          en_out   <= 1'b0;
          data_out <= 2'b00;
          if (done) begin
            score       <= res_high_in - ZERO_V;
            score_valid <= 1'b1;
            state       <= REPORT;
          end
`ifdef SW_FEEDER_TIMEOUT_EN
          else if (drain_cnt == TO_LAST) begin
            err    <= 1'b1;
            count  <= '0;
            rd_ptr <= '0;
            trunc  <= 1'b0;
            state  <= LOAD;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
`endif
        end
        REPORT: begin
          count  <= '0;
          rd_ptr <= '0;
          trunc  <= 1'b0;
          state  <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sw_target_feeder.sv
`default_nettype none
// tb_sw_target_feeder : table of target jobs; streamed bases and reported
// scores are checked against queues filled when the stimulus is driven.
module tb_sw_target_feeder;
  localparam int SW    = 12;
  localparam int DEPTH = 64;
  localparam logic [SW-1:0] Z = 12'd2048;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [1:0]    s_base;
  logic          s_last;
  logic [1:0]    data_out;
  logic [SW-1:0] M_out, I_out, High_out;
  logic          en_out;
  logic          res_vld_in;
  logic [SW-1:0] res_high_in;
  logic          score_valid;
  logic [SW-1:0] score;
  logic          trunc, busy, err;

  always #5 clk = ~clk;

  sw_target_feeder #(
    .SCORE_WIDTH(SW), .ZERO(2048), .DEPTH(DEPTH), .CNT_WIDTH(7), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_base(s_base),
    .s_last(s_last), .data_out(data_out), .M_out(M_out), .I_out(I_out),
    .High_out(High_out), .en_out(en_out), .res_vld_in(res_vld_in),
    .res_high_in(res_high_in), .score_valid(score_valid), .score(score),
    .trunc(trunc), .busy(busy), .err(err)
  );

  typedef struct {
    int          len;
    int          seed;
    logic [SW-1:0] high;
    logic [SW-1:0] exp_s;
    logic        exp_t;
  } job_t;

  typedef struct {
    logic [SW-1:0] s;
    logic          t;
  } res_t;

  int total = 0;
  int bad   = 0;

  logic [1:0] base_q[$];
  res_t       res_q[$];
  int run_len = 0, last_run = -1, runs_done = 0, pulses = 0;
  logic [1:0] mon_b;
  res_t       mon_r;
  job_t       jobs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] base_of(input int i, input int seed);
    int v;
    v = i + seed + (i >> 2);
    return v[1:0];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboards whenever the DUT presents data.
  always @(negedge clk) begin
    if (!rst) begin
      if (en_out) begin
        run_len++;
        if (base_q.size() == 0) check("en_unexpected", 1, 0);
        else begin
          mon_b = base_q.pop_front();
          check("data_out", {30'd0, data_out}, {30'd0, mon_b});
          check("boundary_scores", {M_out, I_out, High_out} == {Z, Z, Z}, 1);
        end
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
        runs_done++;
      end
      if (score_valid) begin
        pulses++;
        if (res_q.size() == 0) check("score_unexpected", 1, 0);
        else begin
          mon_r = res_q.pop_front();
          check("score", {20'd0, score}, {20'd0, mon_r.s});
          check("trunc", {31'd0, trunc}, {31'd0, mon_r.t});
        end
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic send_target(input job_t j);
    for (int i = 0; i < j.len; i++) begin
      if (i % 5 == 4) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_base  = base_of(i, j.seed);
      s_last  = (i == j.len - 1);
      if (i < DEPTH) base_q.push_back(s_base);
      check("s_ready_load", {31'd0, s_ready}, 1);
      tick();
    end
    // Beats offered outside LOAD must be ignored.
    s_base = 2'b11;
    s_last = 1'b1;
    check("en_after_last", {31'd0, en_out}, 0);
    check("busy_stream", {31'd0, busy}, 1);
    check("s_ready_stream", {31'd0, s_ready}, 0);
    tick();
    check("en_first", {31'd0, en_out}, 1);
  endtask

  task automatic run_job(input job_t j, input bit timeout_mode);
    int nexp, r0, p0;
    logic [SW-1:0] prev;
    bit seen;
    nexp = (j.len > DEPTH) ? DEPTH : j.len;
    res_vld_in  = 1'b1;
    res_high_in = '1;
    r0 = runs_done;
    send_target(j);
    seen = 0;
    for (int k = 0; k < DEPTH + 4 && !seen; k++) begin
      tick();
      if (runs_done != r0) seen = 1;
    end
    check("burst_end_seen", {31'd0, seen}, 1);
    check("burst_len", last_run, nexp);
    s_valid = 1'b0;
    s_last  = 1'b0;
    prev = score;
    if (timeout_mode) begin
      res_vld_in = 1'b0;
      for (int k = 0; k < 14; k++) begin
        tick();
        check("err_early", {31'd0, err}, 0);
      end
      tick();
      check("err_pulse", {31'd0, err}, 1);
      check("no_score_on_timeout", {31'd0, score_valid}, 0);
      check("score_kept", {20'd0, score}, {20'd0, prev});
      tick();
      check("err_clear", {31'd0, err}, 0);
      check("s_ready_after_timeout", {31'd0, s_ready}, 1);
    end else begin
      tick();
      tick();
      res_vld_in = 1'b0;
      tick();
      tick();
      res_vld_in  = 1'b1;
      res_high_in = j.high;
      res_q.push_back('{s: j.exp_s, t: j.exp_t});
      p0 = pulses;
      seen = 0;
      for (int k = 0; k < 4 && !seen; k++) begin
        tick();
        if (pulses != p0) seen = 1;
      end
      check("score_pulse_seen", {31'd0, seen}, 1);
      check("busy_report", {31'd0, busy}, 1);
      tick();
      check("pulse_single", pulses, p0 + 1);
      check("busy_fall", {31'd0, busy}, 0);
      check("s_ready_back", {31'd0, s_ready}, 1);
      check("score_hold", {20'd0, score}, {20'd0, j.exp_s});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jobs[0] = '{len: 4,  seed: 0, high: 12'd2056, exp_s: 12'd8,    exp_t: 1'b0};
    jobs[1] = '{len: 70, seed: 1, high: 12'd2148, exp_s: 12'd100,  exp_t: 1'b1};
    jobs[2] = '{len: 1,  seed: 1, high: 12'd2047, exp_s: 12'd4095, exp_t: 1'b0};
    jobs[3] = '{len: 64, seed: 2, high: 12'd0,    exp_s: 12'd2048, exp_t: 1'b0};
    jobs[4] = '{len: 65, seed: 3, high: 12'd4095, exp_s: 12'd2047, exp_t: 1'b1};
    jobs[5] = '{len: 2,  seed: 0, high: 12'd2048, exp_s: 12'd0,    exp_t: 1'b0};

    rst = 1'b1; s_valid = 1'b0; s_base = 2'b00; s_last = 1'b0;
    res_vld_in = 1'b0; res_high_in = '0;
    tick();
    tick();
    check("rst_en", {31'd0, en_out}, 0);
    check("rst_data", {30'd0, data_out}, 0);
    check("rst_bounds", {M_out, I_out, High_out} == {Z, Z, Z}, 1);
    check("rst_score_valid", {31'd0, score_valid}, 0);
    check("rst_score", {20'd0, score}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_ready", {31'd0, s_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 6; n++) run_job(jobs[n], 1'b0);

    // Reset on the second STREAM cycle aborts the burst.
    res_vld_in = 1'b1;
    send_target('{len: 5, seed: 1, high: 12'd0, exp_s: 12'd0, exp_t: 1'b0});
    rst = 1'b1;
    tick();
    check("abort_en", {31'd0, en_out}, 0);
    check("abort_data", {30'd0, data_out}, 0);
    check("abort_ready", {31'd0, s_ready}, 1);
    check("abort_score", {20'd0, score}, 0);
    rst = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    base_q.delete();
    tick();
    check("abort_idle", {31'd0, en_out}, 0);
    run_job('{len: 3, seed: 2, high: 12'd2060, exp_s: 12'd12, exp_t: 1'b0}, 1'b0);

`ifdef SW_FEEDER_TIMEOUT_EN
    run_job('{len: 3, seed: 0, high: 12'd0, exp_s: 12'd0, exp_t: 1'b0}, 1'b1);
    run_job(jobs[0], 1'b0);
`endif

    check("scoreboard_bases_empty", base_q.size(), 0);
    check("scoreboard_results_empty", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
